// File: rtl/msg_frame_tx.sv
// msg_frame_tx: serialises a message into a SOF, LEN, payload, CHK byte frame
// over a valid/ready byte stream, and drops messages whose length is illegal.
module msg_frame_tx #(
    parameter int         NBYTES = 4,
    parameter logic [7:0] SOF    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    input  logic [3:0]            in_nbytes,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_last,
    output logic                  busy,
    output logic                  err_len
);
    typedef enum logic [2:0] {S_IDLE, S_SOF, S_LEN, S_DATA, S_CHK} state_t;

    state_t               state_q, state_d;
    logic [8*NBYTES-1:0]  data_q, data_d, byte_sh;
    logic [3:0]           len_q, len_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           chk_q, chk_d;
    logic                 err_q, err_d;
    logic                 accept, legal, xfer, last_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        accept    = in_valid && in_ready;
        legal     = (in_nbytes != 4'd0) && (in_nbytes <= 4'(NBYTES));
        xfer      = tx_valid && tx_ready;
        last_byte = {1'b0, idx_q} == len_q - 4'd1;
        state_d   = state_q;
        data_d    = data_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        err_d     = accept && !legal;
        case (state_q)
            S_IDLE: if (accept && legal) begin
                state_d = S_SOF;
                data_d  = in_data;
                len_d   = in_nbytes;
                idx_d   = '0;
                chk_d   = '0;
            end
            S_SOF:  if (xfer) state_d = S_LEN;
            S_LEN:  if (xfer) begin
                state_d = S_DATA;
                chk_d   = chk_q ^ tx_data;
            end
            // Index stops at the final byte so it never passes NBYTES-1.
            S_DATA: if (xfer) begin
                chk_d   = chk_q ^ tx_data;
                state_d = last_byte ? S_CHK : S_DATA;
                idx_d   = last_byte ? idx_q : idx_q + 3'd1;
            end
            S_CHK:  if (xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        byte_sh  = data_q >> {idx_q, 3'b000};
        in_ready = (state_q == S_IDLE) && !rst;
        tx_valid = state_q != S_IDLE;
        busy     = state_q != S_IDLE;
        tx_last  = state_q == S_CHK;
        err_len  = err_q;
        tx_data  = (state_q == S_SOF)  ? SOF :
                   (state_q == S_LEN)  ? {4'd0, len_q} :
                   (state_q == S_DATA) ? byte_sh[7:0] :
                   (state_q == S_CHK)  ? chk_q : 8'h00;
    end
endmodule
